uart_tx_data_path: RTL and testbench
====================================

// Module: uart_tx_data_path
// PURPOSE
//  Serialising datapath paired with uart_tx_control_path. Captures the byte, counts bits per
//  state (bit_cnt_o drives the FSM's bit_cnt_i), and computes parity and serial CRC-8 on the fly.
//  Drives the registered UART TX line from the FSM's one-hot state flags; reports ready/done upstream.
// PARAMETERS
//  PARITY_ODD  0     0: even parity bit, 1: odd parity bit
//  CRC_POLY    8'h07 CRC-8 polynomial (MSB-first serial form, x^8 implicit)
//  CRC_INIT    8'h00 CRC register value at frame load
// PORTS
//  clk_i               in   1  clock
//  rst_ni              in   1  asynchronous reset, active low
//  trigger_i           in   1  baud tick, one clk wide; same signal as FSM trgger_i
//  tx_start_i          in   1  request to send tx_data_i (sampled only when idle and trigger_i)
//  tx_data_i           in   8  byte to send, LSB first
//  is_tx_idle_i .. is_tx_stop_i  in 1 each  FSM state flags: idle,start,data,parity,crc,stop
//  changed_tx_state_i  in   1  FSM next_state != current_state
//  bit_cnt_o           out  5  bits completed in current state; to FSM bit_cnt_i
//  tx_ready_o          out  1  = is_tx_idle_i (combinational)
//  tx_done_o           out  1  one-clk pulse at end of stop bits
//  tx_o                out  1  serial line, registered
// BEHAVIOUR
//  Reset (async, rst_ni=0): tx_o=1, bit_cnt_o=0, tx_done_o=0, shreg=0, crc=CRC_INIT, par=0.
//   Applies mid-frame immediately; no partial frame resumes after release.
//  All register updates below happen on clk edges with trigger_i=1 unless stated.
//  Load: is_tx_idle_i & tx_start_i -> shreg<=tx_data_i, crc<=CRC_INIT, par<=0.
//   tx_start_i while not idle ignored; tx_data_i changes after load have no effect.
//  bit_cnt: changed_tx_state_i -> 0; else if !is_tx_idle_i -> +1, saturate 31; idle -> hold 0.
//  Data state, per trigger: b=shreg[0]; shreg<=shreg>>1; par<=par^b;
//   fb=crc[7]^b; crc<={crc[6:0],0} ^ (fb ? CRC_POLY : 0).
//   Last data trigger updates crc and enters CRC state in the same edge.
//  CRC state, per trigger: crc<={crc[6:0],0} (line bit = crc[7], MSB first).
//  Line mux (combinational bit, then registered into tx_o every clk, 1 clk latency):
//   idle:1  start:0  data:shreg[0]  parity:par^PARITY_ODD  crc:crc[7]  stop:1.
//   Parity bit is driven for every bit period the FSM stays in parity state.
//   No flag or >1 flag set (illegal): line bit 1; priority idle>start>data>parity>crc>stop.
//  tx_done_o: 1 for exactly one clk when trigger_i & is_tx_stop_i & changed_tx_state_i; else 0.
//  Back-to-back: tx_start_i held high reloads on the first trigger seen in idle after done.
// STRUCTURE
//  uart_pkg: t_tx_states enum (shared with uart_tx_control_path), CRC8_POLY/CRC8_INIT
//   defaults, UART_DATA_W=8, UART_CNT_W=5.
//  Sub-module uart_crc8_serial: clear/en/bit_i -> crc_o, shift_en for CRC read-out;
//   parameterised by CRC_POLY, CRC_INIT.
//  Top: shreg, parity flop, bit counter, line mux + output flop, done pulse.
// TESTING (paired with uart_tx_control_path, trigger every 4 clk)
//  1 rst_ni low mid data state -> same-cycle tx_o=1, bit_cnt_o=0, tx_done_o=0; idle after release.
//  2 crc_en=0, PARITY_ODD=0, send 8'h01 -> tx_o: 0,1,0,0,0,0,0,0,0, parity 1 (x2), stop 1 (x2).
//  3 crc_en=1, send 8'h01 -> after data bits tx_o = CRC 8'h89 MSB first: 1,0,0,0,1,0,0,1, then stop.
//  4 bit_cnt_o counts 0..7 in data state, returns 0 on trigger entering CRC/parity/stop.
//  5 tx_start_i pulsed mid-frame and tx_data_i changed to 8'hFF after load -> frame unchanged.
//  6 PARITY_ODD=1, send 8'h00 -> parity bit 1; tx_done_o exactly one clk per frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit pair (control path FSM and data path).
package uart_pkg;

  // Transmit FSM states; the control path owns the register, the data path sees one-hot flags.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_CRC    = 3'd4,
    TX_STOP   = 3'd5
  } t_tx_states;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_CNT_W  = 5;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One MSB-first serial CRC-8 step: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb        = crc[7] ^ bit_in;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/uart_crc8_serial.sv
// Serial CRC-8 register: accumulates one bit per enable, then shifts out MSB first.
module uart_crc8_serial
  import uart_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC8_POLY,
  parameter logic [7:0] CRC_INIT = CRC8_INIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  input  logic       shift_en_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_d;
  logic [7:0] crc_q;

  // Next CRC: clear wins, then accumulate, then read-out shift, else hold.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc8_step(crc_q, bit_i, CRC_POLY);
    end else if (shift_en_i) begin
      crc_d = {crc_q[6:0], 1'b0};
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/uart_tx_data_path.sv
// UART TX datapath: byte capture, per-state bit counter, parity, serial CRC-8,
// registered line driver and end-of-frame pulse, steered by the FSM's state flags.
module uart_tx_data_path
  import uart_pkg::*;
#(
  parameter logic       PARITY_ODD = 1'b0,
  parameter logic [7:0] CRC_POLY   = CRC8_POLY,
  parameter logic [7:0] CRC_INIT   = CRC8_INIT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  trigger_i,
  input  logic                  tx_start_i,
  input  logic [UART_DATA_W-1:0] tx_data_i,
  input  logic                  is_tx_idle_i,
  input  logic                  is_tx_start_i,
  input  logic                  is_tx_data_i,
  input  logic                  is_tx_parity_i,
  input  logic                  is_tx_crc_i,
  input  logic                  is_tx_stop_i,
  input  logic                  changed_tx_state_i,
  output logic [UART_CNT_W-1:0] bit_cnt_o,
  output logic                  tx_ready_o,
  output logic                  tx_done_o,
  output logic                  tx_o
);

  logic [UART_DATA_W-1:0] shreg_d, shreg_q;
  logic                   par_d, par_q;
  logic [UART_CNT_W-1:0]  cnt_d, cnt_q;
  logic                   done_d, done_q;
  logic                   tx_q;
  logic                   line_s;
  logic                   load_s;
  logic                   data_step_s;
  logic [7:0]             crc_s;
  logic                   crc_unused_s;
  logic [5:0]             flags_s;
  logic                   flags_legal_s;

  assign load_s      = trigger_i & is_tx_idle_i & tx_start_i;
  assign data_step_s = trigger_i & is_tx_data_i;

  assign flags_s = {is_tx_stop_i, is_tx_crc_i, is_tx_parity_i,
                    is_tx_data_i, is_tx_start_i, is_tx_idle_i};
  // Exactly one flag must be set; anything else parks the line at mark.
  assign flags_legal_s = (flags_s != 6'd0) && ((flags_s & (flags_s - 6'd1)) == 6'd0);

  uart_crc8_serial #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (load_s),
    .en_i       (data_step_s),
    .bit_i      (shreg_q[0]),
    .shift_en_i (trigger_i & is_tx_crc_i),
    .crc_o      (crc_s)
  );

  // Only the MSB leaves the CRC block; the low bits live on inside its shift register.
  assign crc_unused_s = ^crc_s[6:0];

  // Shift register and running parity: load on accepted start, shift one bit per data trigger.
  always_comb begin
    shreg_d = shreg_q;
    par_d   = par_q;
    if (load_s) begin
      shreg_d = tx_data_i;
      par_d   = 1'b0;
    end else if (data_step_s) begin
      shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
      par_d   = par_q ^ shreg_q[0];
    end else begin
      shreg_d = shreg_q;
      par_d   = par_q;
    end
  end

  // Bit counter: cleared on state change or in idle, otherwise counts triggers and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!trigger_i) begin
      cnt_d = cnt_q;
    end else if (changed_tx_state_i || is_tx_idle_i) begin
      cnt_d = '0;
    end else if (cnt_q == {UART_CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + UART_CNT_W'(1);
    end
  end

  // Line bit selected from the current state flag.
  always_comb begin
    line_s = 1'b1;
    if (!flags_legal_s) begin
      line_s = 1'b1;
    end else if (is_tx_idle_i) begin
      line_s = 1'b1;
    end else if (is_tx_start_i) begin
      line_s = 1'b0;
    end else if (is_tx_data_i) begin
      line_s = shreg_q[0];
    end else if (is_tx_parity_i) begin
      line_s = par_q ^ PARITY_ODD;
    end else if (is_tx_crc_i) begin
      line_s = crc_s[7];
    end else begin
      line_s = 1'b1;
    end
  end

  assign done_d = trigger_i & is_tx_stop_i & changed_tx_state_i;

  // Datapath registers; the line and done flops update every clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tx_q    <= line_s;
    end
  end

  assign bit_cnt_o  = cnt_q;
  assign tx_ready_o = is_tx_idle_i;
  assign tx_done_o  = done_q;
  assign tx_o       = tx_q;

endmodule

// File: tb/tb_uart_tx_data_path.sv
// Directed bench for uart_tx_data_path: a small control-path FSM model drives the state
// flags; even- and odd-parity instances share all stimulus.
module tb_uart_tx_data_path;

  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PARITY = 3'd3, S_CRC = 3'd4, S_STOP = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] par_len, stop_len;
  logic       crc_en;
  logic       ovr_en;
  logic [5:0] ovr_flags;

  logic [2:0] st_q, nxt;
  logic [5:0] flags;
  logic       changed;

  logic [4:0] cnt_e, cnt_o;
  logic       rdy_e, rdy_o, done_e, done_o, txo_e, txo_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_e = 0;
  int done_cnt_o = 0;

  typedef struct { logic be; logic bo; logic [4:0] c; } exp_t;

  always #5 clk = ~clk;

  uart_tx_data_path #(.PARITY_ODD(1'b0)) u_dut_even (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trigger), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .is_tx_idle_i(flags[0]), .is_tx_start_i(flags[1]), .is_tx_data_i(flags[2]),
    .is_tx_parity_i(flags[3]), .is_tx_crc_i(flags[4]), .is_tx_stop_i(flags[5]),
    .changed_tx_state_i(changed), .bit_cnt_o(cnt_e), .tx_ready_o(rdy_e),
    .tx_done_o(done_e), .tx_o(txo_e));

  uart_tx_data_path #(.PARITY_ODD(1'b1)) u_dut_odd (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trigger), .tx_start_i(tx_start), .tx_data_i(tx_data),
    .is_tx_idle_i(flags[0]), .is_tx_start_i(flags[1]), .is_tx_data_i(flags[2]),
    .is_tx_parity_i(flags[3]), .is_tx_crc_i(flags[4]), .is_tx_stop_i(flags[5]),
    .changed_tx_state_i(changed), .bit_cnt_o(cnt_o), .tx_ready_o(rdy_o),
    .tx_done_o(done_o), .tx_o(txo_o));

  // Control-path model: next state from trigger, request and the datapath bit counter.
  always_comb begin
    nxt = st_q;
    case (st_q)
      S_IDLE:   if (trigger && tx_start) nxt = S_START;
      S_START:  if (trigger) nxt = S_DATA;
      S_DATA:   if (trigger && cnt_e == 5'd7)
                  nxt = (par_len != 5'd0) ? S_PARITY : (crc_en ? S_CRC : S_STOP);
      S_PARITY: if (trigger && cnt_e == par_len - 5'd1) nxt = crc_en ? S_CRC : S_STOP;
      S_CRC:    if (trigger && cnt_e == 5'd7) nxt = S_STOP;
      S_STOP:   if (trigger && cnt_e == stop_len - 5'd1) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign changed = (nxt != st_q);
  assign flags   = ovr_en ? ovr_flags : (6'b000001 << st_q);

  // Control-path model state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= nxt;
  end

  // Count clocks with tx_done high, sampled away from the active edge.
  always @(negedge clk) begin
    if (done_e === 1'b1) done_cnt_e <= done_cnt_e + 1;
    if (done_o === 1'b1) done_cnt_o <= done_cnt_o + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One baud period: trigger for one clock, then wait until the registered line has settled.
  task automatic bit_period();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input string name, input logic [7:0] data, input logic [7:0] crc_exp,
                            input logic par_even, input logic [4:0] plen, input logic cen,
                            input logic [4:0] slen, input logic noisy, input int abort_at);
    exp_t q[$];
    exp_t e;
    int   d0e, d0o;
    par_len = plen; crc_en = cen; stop_len = slen;
    d0e = done_cnt_e; d0o = done_cnt_o;
    e.be = 1'b0; e.bo = 1'b0; e.c = 5'd0; q.push_back(e);
    for (int i = 0; i < 8; i++) begin e.be = data[i]; e.bo = data[i]; e.c = 5'(i); q.push_back(e); end
    for (int i = 0; i < int'(plen); i++) begin e.be = par_even; e.bo = ~par_even; e.c = 5'(i); q.push_back(e); end
    if (cen) for (int i = 0; i < 8; i++) begin e.be = crc_exp[7-i]; e.bo = crc_exp[7-i]; e.c = 5'(i); q.push_back(e); end
    for (int i = 0; i < int'(slen); i++) begin e.be = 1'b1; e.bo = 1'b1; e.c = 5'(i); q.push_back(e); end

    tx_data = data; tx_start = 1'b1;
    bit_period();
    tx_start = 1'b0;
    if (noisy) tx_data = 8'hFF;
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) bit_period();
      if (noisy) tx_start = (k >= 2 && k <= 12);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check_eq({name, " rst tx_e"}, txo_e, 1'b1);
        check_eq({name, " rst tx_o"}, txo_o, 1'b1);
        check_eq({name, " rst cnt"}, cnt_e, 5'd0);
        check_eq({name, " rst done"}, done_e, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        bit_period();
        check_eq({name, " post-rst tx"}, txo_e, 1'b1);
        check_eq({name, " post-rst ready"}, rdy_e, 1'b1);
        check_eq({name, " post-rst cnt"}, cnt_e, 5'd0);
        return;
      end
      check_eq($sformatf("%s bit%0d even", name, k), txo_e, q[k].be);
      check_eq($sformatf("%s bit%0d odd", name, k), txo_o, q[k].bo);
      check_eq($sformatf("%s cnt%0d", name, k), cnt_e, q[k].c);
    end
    tx_start = 1'b0;
    check_eq({name, " no early done"}, done_cnt_e - d0e, 0);
    bit_period();
    check_eq({name, " idle line"}, txo_e, 1'b1);
    check_eq({name, " ready"}, rdy_e, 1'b1);
    check_eq({name, " done once even"}, done_cnt_e - d0e, 1);
    check_eq({name, " done once odd"}, done_cnt_o - d0o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; trigger = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    par_len = 5'd2; stop_len = 5'd2; crc_en = 1'b0; ovr_en = 1'b0; ovr_flags = 6'd0;
    repeat (3) @(negedge clk);
    check_eq("reset tx", txo_e, 1'b1);
    check_eq("reset cnt", cnt_e, 5'd0);
    check_eq("reset done", done_e, 1'b0);
    check_eq("reset ready", rdy_e, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame("par01",   8'h01, 8'h00, 1'b1, 5'd2, 1'b0, 5'd2, 1'b0, -1);
    send_frame("crc01",   8'h01, 8'h89, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, -1);
    send_frame("zero",    8'h00, 8'h00, 1'b0, 5'd1, 1'b1, 5'd1, 1'b0, -1);
    send_frame("noisy80", 8'h80, 8'h07, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, -1);
    send_frame("abort",   8'h01, 8'h89, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 4);
    send_frame("after",   8'h01, 8'h89, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, -1);

    ovr_en = 1'b1; ovr_flags = 6'b000010;
    repeat (2) @(negedge clk);
    check_eq("ovr start line", txo_e, 1'b0);
    ovr_flags = 6'b000000;
    repeat (2) @(negedge clk);
    check_eq("no flag line", txo_e, 1'b1);
    ovr_flags = 6'b100000;
    repeat (33) bit_period();
    check_eq("cnt saturate", cnt_e, 5'd31);
    ovr_en = 1'b0;
    bit_period();
    check_eq("cnt idle clear", cnt_e, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
